hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline interlock controller for the 5-stage processor. It produces the stalls that forwarding cannot cover.
- It detects load-use hazards between the Execute and Decode stages, then inserts exactly one bubble.
- It sequences the multicycle multdiv unit: issues a one-cycle start, freezes the front end until the result is ready, and raises a timeout if the unit never answers.
- It sits beside the bypass muxes and drives the F/D and D/X latch enables and the D/X nop-select.

Parameters:
- MD_MAX_CYCLES, 40, cycles to wait for md_ready before declaring a timeout.
- CNT_W, 6, width of the multdiv wait counter; must satisfy 2^CNT_W > MD_MAX_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- IR_Decode  in  32  instruction latched in the F/D register.
- IR_Execute  in  32  instruction latched in the D/X register.
- md_ready  in  1  multdiv result valid; single-cycle pulse.
- stall_fd  out  1  1 = hold PC and the F/D register.
- insert_nop  out  1  1 = load 32'b0 into D/X instead of the decoded instruction.
- md_start  out  1  one-cycle start pulse to multdiv.
- md_busy  out  1  high while waiting on multdiv.
- md_timeout  out  1  one-cycle pulse when the wait reaches MD_MAX_CYCLES.

Behaviour:
- Field decode: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
- Opcodes:
  - R-type 00000; lw 01000; sw 00111; addi 00101.
  - bne 00010, blt 00110 (read rd and rs).
  - jr 00100 (reads rd).
  - mul = R-type with aluop 00110; div = R-type with aluop 00111.
- Load-use hazard (combinational, evaluated in IDLE only). Requires IR_Execute opcode == lw and ex_rd != 0, and one of:
  - Decode reads ex_rd as rs (R-type, addi, lw, sw, bne, blt);
  - Decode reads ex_rd as rt (R-type only);
  - Decode reads ex_rd as rd (bne, blt, jr).
- sw data operand (Decode rd == ex_rd) does not stall. The W->M store-data bypass covers it.
- Register 0 never causes a hazard.
- FSM states: IDLE, LW_BUBBLE, MD_WAIT. Reset -> IDLE, counter = 0, all outputs 0.
- IDLE:
  - Mul/div in Execute and md_seen == 0 -> md_start = 1 this cycle, go to MD_WAIT, counter cleared, md_seen set.
  - Else load-use hazard -> stall_fd = 1, insert_nop = 1, go to LW_BUBBLE.
  - Multdiv has priority when both conditions hold.
- LW_BUBBLE:
  - Outputs 0; return to IDLE next cycle.
  - The lw has advanced, so the hazard cannot re-fire for the same pair. Total bubble = exactly 1 cycle.
- MD_WAIT:
  - stall_fd = 1, md_busy = 1, insert_nop = 0. D/X holds the mul/div.
  - md_ready = 1 -> next cycle IDLE; stall drops in that IDLE cycle.
  - Otherwise counter increments.
  - Counter == MD_MAX_CYCLES-1 without ready -> md_timeout pulses, go to IDLE.
  - md_ready on the same cycle as the timeout: ready wins, no timeout pulse.
- md_seen:
  - Cleared when IR_Execute changes, or when IR_Execute is not mul/div.
  - Prevents a re-start of the same instruction held in D/X after completion.
  - Back-to-back identical mul instructions are separated by the pipeline advance; the IR changes via the intervening stage, or a nop on reset.
- md_start is never high in two consecutive cycles. md_start is asserted only in IDLE.
- Reset asserted in any state -> IDLE next edge, all outputs 0, counter 0, md_seen 0. An in-flight multdiv is abandoned.
- Outputs are combinational from state plus registered flags. No output depends on md_ready within the same cycle except the MD_WAIT exit.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BNE, OP_BLT, OP_JR);
  - ALU op constants (ALU_MUL, ALU_DIV);
  - FSM state encoding.
- One natural sub-module: src_reg_decode. Given an instruction, it outputs reads_rs, reads_rt, reads_rd and the three register fields. The bypass logic reuses it.

Test Plan:
- lw r3 in Execute, Decode add r5,r3,r4 -> stall_fd = 1 and insert_nop = 1 for exactly 1 cycle; next cycle all 0.
- lw r3 in Execute, Decode sw r3,0(r7) (rd match, rs = 7) -> no stall. Same with sw r1,0(r3) (rs = 3) -> 1-cycle stall.
- lw r0 in Execute, Decode add r1,r0,r0 -> no stall. lw r3 with Decode bne r3,r2 -> stall.
- mul in Execute, md_ready pulses 5 cycles after md_start -> md_start high 1 cycle, md_busy/stall_fd high 6 cycles, then IDLE with no second md_start.
- div in Execute, md_ready never asserted, MD_MAX_CYCLES = 8 -> md_timeout pulses on cycle 8 of MD_WAIT, then IDLE.
- reset asserted mid-MD_WAIT (cycle 3) -> next edge all outputs 0. After reset release with the same div still in Execute, a fresh md_start is issued.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared ISA field constants and FSM encoding for the pipeline interlock.
package hazard_stall_unit_pkg;
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {ST_IDLE, ST_LW_BUBBLE, ST_MD_WAIT} state_e;

    function automatic logic is_muldiv(input logic [31:0] ir);
        return ir[31:27] == OP_RTYPE && (ir[6:2] == ALU_MUL || ir[6:2] == ALU_DIV);
    endfunction
endpackage

// File: rtl/hazard_stall_unit_src_reg_decode.sv
// src_reg_decode: which source registers an instruction reads, plus its register fields.
module src_reg_decode
    import hazard_stall_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic        reads_rs,
    output logic        reads_rt,
    output logic        reads_rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd
);
    logic [4:0] op;
    logic       unused_low;

    assign op  = instr[31:27];
    assign rd  = instr[26:22];
    assign rs  = instr[21:17];
    assign rt  = instr[16:12];
    assign unused_low = ^instr[11:0];
    // sw's rd is store data, served by the W->M bypass, so it is not a hazard source
    assign reads_rs = op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT};
    assign reads_rt = op == OP_RTYPE;
    assign reads_rd = op inside {OP_BNE, OP_BLT, OP_JR};
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use bubble insertion and multdiv start/wait/timeout sequencing.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 40,
    parameter int CNT_W         = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_Decode,
    input  logic [31:0] IR_Execute,
    input  logic        md_ready,
    output logic        stall_fd,
    output logic        insert_nop,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_timeout
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_MAX_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_seen_q, md_seen_d;
    logic [31:0]      ir_ex_prev_q, ir_ex_prev_d;
    logic             d_reads_rs, d_reads_rt, d_reads_rd;
    logic [4:0]       d_rs, d_rt, d_rd, ex_rd;
    logic             ex_is_md, seen_held, load_use;

    src_reg_decode u_dec (
        .instr    (IR_Decode),
        .reads_rs (d_reads_rs),
        .reads_rt (d_reads_rt),
        .reads_rd (d_reads_rd),
        .rs       (d_rs),
        .rt       (d_rt),
        .rd       (d_rd)
    );

    assign ex_rd        = IR_Execute[26:22];
    assign ex_is_md     = is_muldiv(IR_Execute);
    assign ir_ex_prev_d = IR_Execute;
    // the start flag only survives while the same mul/div stays parked in D/X
    assign seen_held = md_seen_q && ex_is_md && IR_Execute == ir_ex_prev_q;
    assign load_use  = IR_Execute[31:27] == OP_LW && ex_rd != 5'd0 &&
                       ((d_reads_rs && d_rs == ex_rd) ||
                        (d_reads_rt && d_rt == ex_rd) ||
                        (d_reads_rd && d_rd == ex_rd));

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        md_seen_d  = seen_held;
        stall_fd   = 1'b0;
        insert_nop = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        md_timeout = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (ex_is_md && !seen_held) begin
                        md_start  = 1'b1;
                        md_busy   = 1'b1;
                        stall_fd  = 1'b1;
                        md_seen_d = 1'b1;
                        state_d   = ST_MD_WAIT;
                    end else if (load_use) begin
                        stall_fd   = 1'b1;
                        insert_nop = 1'b1;
                        state_d    = ST_LW_BUBBLE;
                    end
                end
                ST_LW_BUBBLE: state_d = ST_IDLE;
                ST_MD_WAIT: begin
                    stall_fd = 1'b1;
                    md_busy  = 1'b1;
                    if (md_ready) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        md_timeout = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            md_seen_q    <= 1'b0;
            ir_ex_prev_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            md_seen_q    <= md_seen_d;
            ir_ex_prev_q <= ir_ex_prev_d;
        end
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vector table, timeout latency sequence and randomized run against a behavioural model.
module tb_hazard_stall_unit;
    localparam int MAXC = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR_Decode = '0, IR_Execute = '0;
    logic        md_ready = 1'b0;
    logic        stall_fd, insert_nop, md_start, md_busy, md_timeout;

    int checks = 0;
    int failures = 0;

    hazard_stall_unit #(.MD_MAX_CYCLES(MAXC), .CNT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .IR_Decode  (IR_Decode),
        .IR_Execute (IR_Execute),
        .md_ready   (md_ready),
        .stall_fd   (stall_fd),
        .insert_nop (insert_nop),
        .md_start   (md_start),
        .md_busy    (md_busy),
        .md_timeout (md_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ir_d;
        logic [31:0] ir_x;
        logic        rdy;
        logic        rst;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int alu);
        return {op[4:0], rd[4:0], rs[4:0], rt[4:0], 5'd0, alu[4:0], 2'd0};
    endfunction

    function automatic bit is_md(input logic [31:0] i);
        return i[31:27] == 5'd0 && (i[6:2] == 5'd6 || i[6:2] == 5'd7);
    endfunction

    function automatic bit reads(input logic [31:0] i, input logic [4:0] r);
        int op;
        op = int'(i[31:27]);
        if (r == 5'd0) return 1'b0;
        if (i[21:17] == r && op inside {0, 8, 7, 5, 2, 6}) return 1'b1;
        if (i[16:12] == r && op == 0) return 1'b1;
        if (i[26:22] == r && op inside {2, 6, 4}) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_instr();
        int r1, r2, r3, sel;
        r1 = $urandom_range(0, 3);
        r2 = $urandom_range(0, 3);
        r3 = $urandom_range(0, 3);
        sel = $urandom_range(0, 9);
        case (sel)
            0: return enc(0, r1, r2, r3, 0);
            1: return enc(0, r1, r2, r3, 6);
            2: return enc(0, r1, r2, r3, 7);
            3, 4: return enc(8, r1, r2, r3, 0);
            5: return enc(7, r1, r2, r3, 0);
            6: return enc(5, r1, r2, r3, 0);
            7: return enc(2, r1, r2, r3, 0);
            8: return enc(6, r1, r2, r3, 0);
            default: return enc(4, r1, r2, r3, 0);
        endcase
    endfunction

    function automatic logic [4:0] outs();
        return {stall_fd, insert_nop, md_start, md_busy, md_timeout};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] d, input logic [31:0] x, input logic rdy, input logic rst,
                       input logic [4:0] e, input int reps = 1);
        vec_t v;
        v.ir_d = d; v.ir_x = x; v.rdy = rdy; v.rst = rst; v.exp = e;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    logic [31:0] lw3, lw0, add534, add543, sw37, sw13, add100, bne32, addi_rt3, jr3, mul, dv, dv2;
    int          n;
    int          m_wait;
    bit          m_bub, m_seen, held, e_start, e_hz, prev_start;
    logic [31:0] m_prev;
    logic [4:0]  e;

    initial begin
        lw3 = enc(8, 3, 1, 0, 0);      lw0 = enc(8, 0, 1, 0, 0);
        add534 = enc(0, 5, 3, 4, 0);   add543 = enc(0, 5, 4, 3, 0);
        sw37 = enc(7, 3, 7, 0, 0);     sw13 = enc(7, 1, 3, 0, 0);
        add100 = enc(0, 1, 0, 0, 0);   bne32 = enc(2, 3, 2, 0, 0);
        addi_rt3 = enc(5, 5, 4, 3, 0); jr3 = enc(4, 3, 0, 0, 0);
        mul = enc(0, 1, 2, 3, 6);      dv = enc(0, 4, 5, 6, 7);
        dv2 = enc(0, 7, 5, 6, 7);
        // {stall_fd, insert_nop, md_start, md_busy, md_timeout}
        add(0, 0, 0, 1, 5'b00000, 2);
        add(add534, lw3, 0, 0, 5'b11000);
        add(add534, 0, 0, 0, 5'b00000);
        add(0, add534, 0, 0, 5'b00000);
        add(sw37, lw3, 0, 0, 5'b00000);
        add(sw13, lw3, 0, 0, 5'b11000);
        add(sw13, 0, 0, 0, 5'b00000);
        add(add100, lw0, 0, 0, 5'b00000);
        add(bne32, lw3, 0, 0, 5'b11000);
        add(0, 0, 0, 0, 5'b00000);
        add(add543, lw3, 0, 0, 5'b11000);
        add(0, 0, 0, 0, 5'b00000);
        add(addi_rt3, lw3, 0, 0, 5'b00000);
        add(jr3, lw3, 0, 0, 5'b11000);
        add(jr3, lw3, 0, 0, 5'b00000);
        add(0, 0, 0, 0, 5'b00000);
        add(0, mul, 0, 0, 5'b10110);
        add(0, mul, 0, 0, 5'b10010, 4);
        add(0, mul, 1, 0, 5'b10010);
        add(0, mul, 0, 0, 5'b00000);
        add(0, mul, 1, 0, 5'b00000);
        add(0, 0, 0, 0, 5'b00000);
        add(0, dv, 0, 0, 5'b10110);
        add(0, dv, 0, 0, 5'b10010, MAXC - 1);
        add(0, dv, 0, 0, 5'b10011);
        add(0, dv, 0, 0, 5'b00000);
        add(0, 0, 0, 0, 5'b00000);
        add(0, dv, 0, 0, 5'b10110);
        add(0, dv, 0, 0, 5'b10010, MAXC - 1);
        add(0, dv, 1, 0, 5'b10010);
        add(0, dv, 0, 0, 5'b00000);
        add(0, 0, 0, 0, 5'b00000);
        add(0, dv2, 0, 0, 5'b10110);
        add(0, dv2, 0, 0, 5'b10010, 2);
        add(0, dv2, 0, 1, 5'b00000, 2);
        add(0, dv2, 0, 0, 5'b10110);
        add(0, dv2, 1, 0, 5'b10010);
        add(0, dv2, 0, 0, 5'b00000);

        foreach (vecs[i]) begin
            @(negedge clock);
            IR_Decode = vecs[i].ir_d; IR_Execute = vecs[i].ir_x;
            md_ready = vecs[i].rdy;   reset = vecs[i].rst;
            #1;
            chk($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
        end

        // timeout latency: md_timeout must appear exactly MAXC cycles after md_start
        @(negedge clock);
        reset = 1'b1; IR_Execute = '0; IR_Decode = '0; md_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0; IR_Execute = mul;
        #1;
        n = -1;
        for (int c = 0; c < 4 * MAXC && n < 0; c++) begin
            if (md_timeout) n = c;
            else begin
                @(negedge clock);
                #1;
            end
        end
        chk("timeout_latency", n, MAXC);

        m_wait = -1; m_bub = 0; m_seen = 0; m_prev = '0; prev_start = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            reset = (cyc == 0) || ($urandom_range(0, 199) == 0);
            md_ready = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) IR_Execute = rand_instr();
            if ($urandom_range(0, 1) == 0) IR_Decode = rand_instr();
            #1;
            e = '0; e_start = 0; e_hz = 0;
            held = m_seen && IR_Execute == m_prev && is_md(IR_Execute);
            if (!reset) begin
                if (m_wait >= 0) begin
                    e = {1'b1, 1'b0, 1'b0, 1'b1, (!md_ready && m_wait == MAXC - 1)};
                end else if (!m_bub) begin
                    if (is_md(IR_Execute) && !held) begin
                        e_start = 1; e = 5'b10110;
                    end else if (IR_Execute[31:27] == 5'd8 && reads(IR_Decode, IR_Execute[26:22])) begin
                        e_hz = 1; e = 5'b11000;
                    end
                end
            end
            chk($sformatf("rand%0d", cyc), int'(outs()), int'(e));
            if (prev_start) chk("start_twice", int'(md_start), 0);
            prev_start = md_start;
            if (reset) begin
                m_wait = -1; m_bub = 0; m_seen = 0;
            end else begin
                m_seen = e_start || held;
                m_bub = e_hz;
                if (e_start) m_wait = 0;
                else if (m_wait >= 0) m_wait = (md_ready || m_wait == MAXC - 1) ? -1 : m_wait + 1;
            end
            m_prev = IR_Execute;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
